// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage ARM pipeline control logic.
package cpu_pkg;

  localparam int REG_W = 4;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Read-after-write hazard detection for the instruction in ID against
// the destinations in flight in EXE and MEM.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src1_valid,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             raw_hazard
);

  logic [REG_W-1:0] srcs [2];
  logic [1:0]       used;
  logic [1:0]       match;

  assign srcs[0] = src1;
  assign srcs[1] = src2;
  assign used    = {two_src, src1_valid};

  // With forwarding only a load still in EXE cannot be bypassed in time.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic fwd_match;
    logic nofwd_match;
    assign fwd_match   = exe_mem_r_en & exe_wb_en & (exe_dest == srcs[gi]);
    assign nofwd_match = (exe_wb_en & (exe_dest == srcs[gi])) |
                         (mem_wb_en & (mem_dest == srcs[gi]));
    assign match[gi]   = used[gi] & (FORWARD_EN ? fwd_match : nofwd_match);
  end

  assign raw_hazard = |match;

endmodule

// File: rtl/pipeline_controller.sv
// Hazard, flush and freeze control for the pipeline registers, with an
// SRAM wait FSM, a watchdog and saturating stall/flush counters.
module pipeline_controller
  import cpu_pkg::*;
#(
  parameter bit FORWARD_EN  = 1'b0,
  parameter int MEM_TIMEOUT = 63,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src1_valid,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             exe_b,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             hazard_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pipe_freeze,
  output logic             mem_start,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  mem_state_t       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic             raw_hazard;
  logic             timeout_hit;

  hazard_detect #(
    .FORWARD_EN(FORWARD_EN)
  ) u_hazard_detect (
    .src1        (src1),
    .src2        (src2),
    .src1_valid  (src1_valid),
    .two_src     (two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .raw_hazard  (raw_hazard)
  );

  assign timeout_hit = (state_reg == MEM_BUSY) && (wait_cnt_reg == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= MEM_IDLE;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
      stall_cnt_reg   <= stall_cnt_next;
      flush_cnt_reg   <= flush_cnt_next;
    end
  end

  // A completed access takes precedence over a coincident watchdog expiry.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    case (state_reg)
      MEM_IDLE: begin
        if (mem_access && !mem_ready) begin
          state_next    = MEM_BUSY;
          wait_cnt_next = '0;
        end
      end
      MEM_BUSY: begin
        if (mem_ready) begin
          state_next = MEM_IDLE;
        end else if (timeout_hit) begin
          state_next       = MEM_IDLE;
          mem_timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    hazard_freeze = 1'b0;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    mem_start     = mem_access && (state_reg == MEM_IDLE);
    pipe_freeze   = mem_access && !mem_ready && !timeout_hit;
    // A frozen ID/EX keeps exe_b alive, so the flush simply waits.
    if (pipe_freeze) begin
      hazard_freeze = 1'b0;
    end else if (exe_b) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (raw_hazard) begin
      hazard_freeze = 1'b1;
      id_flush      = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if ((hazard_freeze || pipe_freeze) && (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    if (if_flush && (flush_cnt_reg != '1))
      flush_cnt_next = flush_cnt_reg + CNT_W'(1);
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: instance a uses defaults, instance b uses forwarding,
// a 3-cycle watchdog and 4-bit counters; both share the same stimulus.
module tb_pipeline_controller;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic src1_valid, two_src, exe_wb_en, exe_mem_r_en, exe_b;
  logic mem_wb_en, mem_access, mem_ready;

  logic a_hf, a_if, a_id, a_pf, a_ms, a_to;
  logic [15:0] a_stall, a_flush;
  logic b_hf, b_if, b_id, b_pf, b_ms, b_to;
  logic [3:0] b_stall, b_flush;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pipeline_controller #(
    .FORWARD_EN(1'b0), .MEM_TIMEOUT(63), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2),
    .src1_valid(src1_valid), .two_src(two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_b(exe_b),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .mem_ready(mem_ready), .hazard_freeze(a_hf), .if_flush(a_if),
    .id_flush(a_id), .pipe_freeze(a_pf), .mem_start(a_ms),
    .mem_timeout(a_to), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipeline_controller #(
    .FORWARD_EN(1'b1), .MEM_TIMEOUT(3), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2),
    .src1_valid(src1_valid), .two_src(two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_b(exe_b),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .mem_ready(mem_ready), .hazard_freeze(b_hf), .if_flush(b_if),
    .id_flush(b_id), .pipe_freeze(b_pf), .mem_start(b_ms),
    .mem_timeout(b_to), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    src1_valid = 1'b0; two_src = 1'b0; exe_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; exe_b = 1'b0; mem_wb_en = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_stall_a", a_stall, 0);
    check("rst_flush_a", a_flush, 0);
    check("rst_timeout_b", b_to, 0);
    check("rst_hf_a", a_hf, 0);
    rst = 1'b0;

    // EXE-stage RAW on src1, with and without a load in EXE
    src1 = 4'd3; src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1;
    check("raw_hf_a", a_hf, 1);
    check("raw_id_a", a_id, 1);
    check("raw_if_a", a_if, 0);
    check("raw_fwd_hf_b", b_hf, 0);
    tick();
    check("raw_stall_a", a_stall, 1);
    check("raw_fwd_stall_b", b_stall, 0);
    exe_mem_r_en = 1'b1;
    #1;
    check("load_use_hf_b", b_hf, 1);
    check("load_use_id_b", b_id, 1);
    tick();
    check("load_use_stall_b", b_stall, 1);
    check("load_use_stall_a", a_stall, 2);
    clear_inputs();

    // MEM-stage RAW on src2
    src2 = 4'd7; two_src = 1'b1; mem_dest = 4'd7; mem_wb_en = 1'b1;
    #1;
    check("mem_raw_hf_a", a_hf, 1);
    check("mem_raw_fwd_hf_b", b_hf, 0);
    two_src = 1'b0;
    #1;
    check("src2_unused_hf_a", a_hf, 0);
    two_src = 1'b1; mem_dest = 4'd6;
    #1;
    check("dest_differs_hf_a", a_hf, 0);
    mem_dest = 4'd7;
    tick();
    check("mem_raw_stall_a", a_stall, 3);
    clear_inputs();

    // Branch overrides a simultaneous hazard
    src1 = 4'd3; src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    exe_mem_r_en = 1'b1; exe_b = 1'b1;
    #1;
    check("br_if_a", a_if, 1);
    check("br_id_a", a_id, 1);
    check("br_hf_a", a_hf, 0);
    check("br_if_b", b_if, 1);
    tick();
    check("br_flush_a", a_flush, 1);
    check("br_stall_a", a_stall, 3);
    check("br_flush_b", b_flush, 1);
    check("br_stall_b", b_stall, 1);
    clear_inputs();

    // Five-cycle SRAM wait with a deferred branch behind it
    mem_access = 1'b1; exe_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("wait%0d_pf_a", k), a_pf, 1);
      check($sformatf("wait%0d_ms_a", k), a_ms, (k == 1) ? 1 : 0);
      check($sformatf("wait%0d_if_a", k), a_if, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("ready_pf_a", a_pf, 0);
    check("ready_ms_a", a_ms, 0);
    check("deferred_if_a", a_if, 1);
    tick();
    check("wait_stall_a", a_stall, 8);
    check("wait_flush_a", a_flush, 2);
    exe_b = 1'b0;
    #1;
    check("idle_again_ms_a", a_ms, 1);
    check("same_cycle_ready_pf_a", a_pf, 0);
    tick();
    check("stays_idle_ms_a", a_ms, 1);
    check("timeout_seen_b", b_to, 1);
    clear_inputs();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_stall_a", a_stall, 0);
    check("rst2_flush_a", a_flush, 0);
    check("rst2_stall_b", b_stall, 0);
    check("rst2_timeout_b", b_to, 0);

    // Watchdog on b: four frozen cycles, release in the fifth
    mem_access = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("wd%0d_pf_b", k), b_pf, 1);
      check($sformatf("wd%0d_to_b", k), b_to, 0);
      tick();
    end
    #1;
    check("wd_release_pf_b", b_pf, 0);
    tick();
    check("wd_fired_b", b_to, 1);
    check("wd_stall_b", b_stall, 4);
    check("wd_stall_a", a_stall, 5);
    mem_access = 1'b0;
    repeat (3) tick();
    check("wd_sticky_b", b_to, 1);

    // Reset while a is still waiting in MEM_BUSY
    mem_access = 1'b1;
    #1;
    check("busy_ms_a", a_ms, 0);
    check("busy_pf_a", a_pf, 1);
    rst = 1'b1; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy_ms_a", a_ms, 1);
    check("rst_busy_pf_a", a_pf, 0);
    check("rst_busy_stall_a", a_stall, 0);
    check("rst_busy_to_b", b_to, 0);
    clear_inputs();

    // Counter saturation on the 4-bit instance
    src1 = 4'd3; src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    exe_mem_r_en = 1'b1;
    repeat (20) tick();
    check("sat_stall_b", b_stall, 15);
    check("sat_stall_a", a_stall, 20);
    exe_b = 1'b1;
    repeat (20) tick();
    check("sat_flush_b", b_flush, 15);
    check("sat_flush_a", a_flush, 20);
    check("br_no_stall_a", a_stall, 20);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard, flush and freeze controller for the five-stage ARM pipeline. It sees the register sources of the instruction in ID, the destinations of the instructions in EXE and MEM, the branch bit leaving the ID/EX register, and the SRAM handshake. It drives the freeze and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- FORWARD_EN, default 0: 1 means a forwarding unit exists, so only load-use hazards stall.
- MEM_TIMEOUT, default 63: maximum number of cycles in MEM_BUSY before the watchdog fires.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- src1  in  4  Rn of the ID instruction.
- src2  in  4  Rm, or Rd for STR, of the ID instruction.
- src1_valid  in  1  ID instruction reads src1.
- two_src  in  1  ID instruction reads src2.
- exe_dest  in  4  WBDest at the ID/EX output.
- exe_wb_en  in  1  WB_EN at the ID/EX output.
- exe_mem_r_en  in  1  MEM_R_EN at the ID/EX output.
- exe_b  in  1  B at the ID/EX output; the branch is taken.
- mem_dest  in  4  destination in the MEM stage.
- mem_wb_en  in  1  write-back enable in the MEM stage.
- mem_access  in  1  MEM stage does a load or store.
- mem_ready  in  1  SRAM controller has completed the access.
- hazard_freeze  out  1  hold PC and IF/ID.
- if_flush  out  1  clear IF/ID.
- id_flush  out  1  clear ID/EX; drives its flush input.
- pipe_freeze  out  1  hold every pipeline register and the PC.
- mem_start  out  1  one-cycle request pulse to the SRAM controller.
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  count of stalled cycles.
- flush_cnt  out  CNT_W  count of branch flushes.

## Operation
- Memory FSM has two states, MEM_IDLE and MEM_BUSY.
  - MEM_IDLE → MEM_BUSY when mem_access & !mem_ready.
  - MEM_BUSY → MEM_IDLE when mem_ready, or when wait_cnt == MEM_TIMEOUT.
  - On a timeout, set mem_timeout; it is cleared only by rst.
- mem_start = mem_access & state==MEM_IDLE.
- pipe_freeze = mem_access & !mem_ready & !(state==MEM_BUSY & wait_cnt==MEM_TIMEOUT).
- Source-match condition m(s), applied to src1 when src1_valid and to src2 when two_src:
  - FORWARD_EN=0: (exe_wb_en & exe_dest==s) | (mem_wb_en & mem_dest==s).
  - FORWARD_EN=1: exe_mem_r_en & exe_wb_en & exe_dest==s.
- raw_hazard = m(src1)·src1_valid | m(src2)·two_src.
- Output priority, highest first:
  1. pipe_freeze: force hazard_freeze = if_flush = id_flush = 0.
  2. exe_b: if_flush = id_flush = 1, hazard_freeze = 0. The ID instruction is squashed, so its hazard is irrelevant.
  3. raw_hazard: hazard_freeze = 1, id_flush = 1 (a bubble into ID/EX).
  4. Otherwise: all outputs 0.
- stall_cnt increments when hazard_freeze | pipe_freeze is 1.
- flush_cnt increments when if_flush is 1.
- Both counters saturate at 2^CNT_W−1.

## Timing
- hazard_freeze, if_flush, id_flush, pipe_freeze and mem_start are combinational from the inputs and registered state, with zero latency. They take effect at the next clk edge.
- The state, wait_cnt, mem_timeout and both counters are registered.
- Reset: on rst at a clk edge, state=MEM_IDLE, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- With rst high, combinational outputs still follow the inputs. The pipeline registers are themselves in reset.
- wait_cnt:
  - Clears on entry to MEM_BUSY.
  - Increments each cycle in MEM_BUSY.
  - A timeout fires after MEM_TIMEOUT+1 frozen cycles. pipe_freeze drops in the MEM_TIMEOUT cycle itself.
- mem_ready in the same cycle as mem_start: no freeze, and the FSM stays in MEM_IDLE.
- mem_ready while in MEM_BUSY: pipe_freeze is 0 that cycle and the FSM returns to MEM_IDLE. mem_start is not re-asserted for the same access.
- exe_b during pipe_freeze: the flush is deferred, not lost. The ID/EX register holds, so exe_b persists until the freeze releases.
- rst mid-MEM_BUSY: the FSM returns to MEM_IDLE on that edge.

## Structure
- Shared package cpu_pkg holds:
  - typedef mem_state_t (MEM_IDLE, MEM_BUSY).
  - constant REG_W=4.
- Sub-module hazard_detect: purely combinational; computes raw_hazard from src1/src2/dest/enable inputs and FORWARD_EN.
- The top level holds the FSM, the priority logic and the counters.

## Test plan
- FORWARD_EN=0, src1=3, src1_valid=1, exe_dest=3, exe_wb_en=1 → hazard_freeze=1, id_flush=1, stall_cnt +1.
- FORWARD_EN=1, same stimulus with exe_mem_r_en=0 → no stall. With exe_mem_r_en=1 → a one-cycle stall.
- exe_b=1 together with raw_hazard=1 → if_flush=1, id_flush=1, hazard_freeze=0, flush_cnt +1.
- mem_access=1 and mem_ready held low for 5 cycles → mem_start pulses once, pipe_freeze=1 for 5 cycles, stall_cnt=5, state returns to MEM_IDLE.
- mem_ready never asserted, MEM_TIMEOUT=3 → mem_timeout=1 after 4 cycles, pipe_freeze released, mem_timeout stays set until rst.
- CNT_W=4 with 20 hazard cycles → stall_cnt=15. Assert rst mid-MEM_BUSY → all registered outputs are 0 and state is MEM_IDLE at the next edge.
